alu_req_scheduler: RTL and testbench
====================================

// Module: alu_req_scheduler
// PURPOSE
//  Shares one ALU instance between NUM_REQ requesters. Arbitrates requests, latches the winner's operands,
//  drives the ALU (ce/mode/cmd/opa/opb/cin/inp_valid), waits the command-dependent latency, and returns
//  res plus flags tagged with the requester id. One operation in flight at a time.
// PARAMETERS
//  NUM_REQ  4         number of requesters, 2..8
//  WIDTH    `WIDTH    operand width (8); result is WIDTH+1
//  ALU_LAT  1         cycles from issue edge to valid ALU outputs, non-multiply cmds (>=1)
//  MUL_LAT  3         same, multiply cmds (mode=1, cmd 4'd9 or 4'd10) (>=1)
// PORTS
//  clk            in   1                 clock, all logic on posedge
//  rst_n          in   1                 asynchronous, active-low reset
//  req            in   NUM_REQ           request per requester; held with payload until gnt
//  req_mode       in   NUM_REQ           per-requester mode
//  req_cmd        in   NUM_REQ*4         per-requester cmd, packed [i*4+:4]
//  req_opa/opb    in   NUM_REQ*WIDTH     per-requester operands, packed
//  req_cin        in   NUM_REQ           per-requester carry-in
//  req_inp_valid  in   NUM_REQ*2         per-requester inp_valid, packed
//  gnt            out  NUM_REQ           one-hot, one-cycle pulse: payload captured
//  alu_ce/mode/cin out 1                 to ALU
//  alu_cmd        out  4                 to ALU
//  alu_opa/opb    out  WIDTH             to ALU
//  alu_inp_valid  out  2                 to ALU
//  alu_res        in   WIDTH+1           from ALU
//  alu_flags      in   6                 from ALU {err,oflow,cout,g,l,e}
//  rsp_valid      out  1                 response valid
//  rsp_ready      in   1                 response accepted when valid&ready
//  rsp_id         out  $clog2(NUM_REQ)   requester served
//  rsp_res        out  WIDTH+1           captured result
//  rsp_flags      out  6                 captured {err,oflow,cout,g,l,e}
// BEHAVIOUR
//  - Reset (rst_n=0, async): state IDLE; gnt, rsp_valid, alu_ce = 0; all data outputs 0; rr_ptr=0;
//    in-flight op discarded, no response emitted. Exit on first posedge with rst_n=1.
//  - FSM IDLE->ISSUE->WAIT->RESP->IDLE; all outputs registered.
//  - IDLE: any req -> pick winner, latch payload, gnt[winner]=1 next cycle, go ISSUE. No req: stay.
//  - ISSUE (1 cycle): alu_ce=1, latched payload on ALU ports; cnt loaded with lat-1
//    (lat = MUL_LAT if multiply cmd else ALU_LAT); go WAIT.
//  - WAIT: alu_ce=1, payload held stable; cnt==0 -> capture alu_res/alu_flags into rsp_*, go RESP;
//    else cnt-1. Issue-to-rsp_valid = lat+1 cycles; req-to-gnt = 1 cycle.
//  - RESP: alu_ce=0 (ALU holds outputs); rsp_valid=1, rsp_* stable until rsp_ready=1; then
//    rsp_valid=0, rr_ptr=(winner+1) mod NUM_REQ, IDLE. Next grant earliest cycle after handshake.
//  - Arbitration: round-robin from rr_ptr; requester just served is lowest priority next round.
//  - req dropped before gnt: never granted. req asserted during ISSUE/WAIT/RESP: waits, no gnt.
//  - inp_valid=0 or illegal cmd passed unchanged; ALU err flag returned in rsp_flags[5].
//  - No overflow of cnt: width $clog2(max(ALU_LAT,MUL_LAT))+1.
// CONFIGURATION
//  ALU_SCHED_FIXED_PRIO_EN defined: fixed priority, lowest index wins; rr_ptr unused (held 0).
//  Undefined (default): round-robin as above.
// STRUCTURE
//  Package alu_sched_pkg: state enum {IDLE,ISSUE,WAIT,RESP}; flag struct {err,oflow,cout,g,l,e};
//  CMD_MUL_INC=4'd9, CMD_MUL_SHL=4'd10; function is_mul(mode,cmd).
//  Sub-module rr_arbiter (req, ptr -> one-hot grant, grant index; fixed-prio under macro).
// TESTING
//  1 Reset mid-WAIT: rst_n=0 during MUL op -> gnt/rsp_valid/alu_ce=0 same cycle, no rsp after release.
//  2 Single req[2], mode=1 cmd=0 (ADD) opa=8'hF0 opb=8'h20 -> gnt[2] cycle+1, rsp_valid cycle+3,
//    rsp_id=2, rsp_res=9'h110, cout=1.
//  3 MUL: mode=1 cmd=9 opa=3 opb=4 -> rsp_res=9'd20 exactly MUL_LAT+1 cycles after ISSUE.
//  4 All 4 req held high -> grant order 0,1,2,3,0 (round-robin); fixed-prio build -> 0,0,0.
//  5 rsp_ready=0 for 5 cycles -> rsp_* stable, no new gnt; ready=1 -> next gnt 1 cycle later.
//  6 req[1] with inp_valid=2'b00 -> rsp_flags[5](err)=1, rsp_id=1, FSM returns to IDLE.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types and helpers for the ALU request scheduler: FSM state encoding,
// ALU flag bundle layout and multiply-command detection.
`ifndef WIDTH
`define WIDTH 8
`endif

package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Bit order matches the ALU flag bus {err,oflow,cout,g,l,e}.
  typedef struct packed {
    logic err;
    logic oflow;
    logic cout;
    logic g;
    logic l;
    logic e;
  } flags_t;

  localparam logic [3:0] CMD_MUL_INC = 4'd9;
  localparam logic [3:0] CMD_MUL_SHL = 4'd10;

  // Multiply commands only exist in arithmetic mode and take the long latency.
  function automatic logic is_mul(input logic mode, input logic [3:0] cmd);
    return mode && ((cmd == CMD_MUL_INC) || (cmd == CMD_MUL_SHL));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: picks one requester starting the search at ptr and
// returns both a one-hot grant and its index.
// Build option: ALU_SCHED_FIXED_PRIO_EN selects fixed priority (lowest index
// wins) and ignores ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx
);

  logic [IDW-1:0] cand;

`ifdef ALU_SCHED_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Scan from the highest index down so the lowest requesting index is kept.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, otherwise the tool infers a latch for the idle paths.
    grant_idx = '0;
    cand      = '0;
    grant     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDW'(k);
      if (req[cand]) grant_idx = cand;
    end
    if (|req) grant[grant_idx] = 1'b1;
  end
`else
  // Scan the circular order backwards from ptr+N-1 to ptr so the first
  // requester at or after ptr overwrites all others.
  always_comb begin
    grant_idx = '0;
    cand      = '0;
    grant     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) grant_idx = cand;
    end
    if (|req) grant[grant_idx] = 1'b1;
  end
`endif

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one ALU between NUM_REQ requesters: arbitrates, latches the winning
// payload onto the ALU ports, waits the command-dependent latency and returns
// the result tagged with the requester id. One operation in flight at a time.
// Build option: ALU_SCHED_FIXED_PRIO_EN selects fixed-priority arbitration
// (rr_ptr then stays 0); default is round-robin.
`ifndef WIDTH
`define WIDTH 8
`endif

module alu_req_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = `WIDTH,
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_mode,
  input  logic [NUM_REQ*4-1:0]       req_cmd,
  input  logic [NUM_REQ*WIDTH-1:0]   req_opa,
  input  logic [NUM_REQ*WIDTH-1:0]   req_opb,
  input  logic [NUM_REQ-1:0]         req_cin,
  input  logic [NUM_REQ*2-1:0]       req_inp_valid,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       alu_ce,
  output logic                       alu_mode,
  output logic                       alu_cin,
  output logic [3:0]                 alu_cmd,
  output logic [WIDTH-1:0]           alu_opa,
  output logic [WIDTH-1:0]           alu_opb,
  output logic [1:0]                 alu_inp_valid,
  input  logic [WIDTH:0]             alu_res,
  input  logic [5:0]                 alu_flags,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH:0]             rsp_res,
  output logic [5:0]                 rsp_flags
);

  localparam int IDW     = $clog2(NUM_REQ);
  localparam int MAX_LAT = (ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  state_t             state;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     win_id;
  logic [CNT_W-1:0]   cnt;
  flags_t             rsp_flags_q;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDW-1:0]     arb_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req       (req),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign rsp_flags = rsp_flags_q;

  // Scheduler FSM: every output, including the ALU port payload, is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      win_id        <= '0;
      cnt           <= '0;
      gnt           <= '0;
      alu_ce        <= 1'b0;
      alu_mode      <= 1'b0;
      alu_cin       <= 1'b0;
      alu_cmd       <= '0;
      alu_opa       <= '0;
      alu_opb       <= '0;
      alu_inp_valid <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_res       <= '0;
      rsp_flags_q   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch
      // reads the pre-edge values regardless of statement order.
      gnt <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt           <= arb_grant;
            win_id        <= arb_idx;
            alu_ce        <= 1'b1;
            alu_mode      <= req_mode[arb_idx];
            alu_cin       <= req_cin[arb_idx];
            alu_cmd       <= req_cmd[int'(arb_idx)*4 +: 4];
            alu_opa       <= req_opa[int'(arb_idx)*WIDTH +: WIDTH];
            alu_opb       <= req_opb[int'(arb_idx)*WIDTH +: WIDTH];
            alu_inp_valid <= req_inp_valid[int'(arb_idx)*2 +: 2];
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          // The ALU samples the payload at this edge; count its latency.
          cnt   <= is_mul(alu_mode, alu_cmd) ? CNT_W'(MUL_LAT - 1)
                                             : CNT_W'(ALU_LAT - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_res     <= alu_res;
            rsp_flags_q <= flags_t'(alu_flags);
            rsp_id      <= win_id;
            rsp_valid   <= 1'b1;
            alu_ce      <= 1'b0;
            state       <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
`ifndef ALU_SCHED_FIXED_PRIO_EN
            rr_ptr    <= (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + IDW'(1);
`endif
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Self-checking bench for alu_req_scheduler: directed scenarios followed by
// randomized traffic, checked by a transaction-level reference model and a
// scoreboard queue. A behavioural ALU with the proper latencies sits on the
// ALU ports and presents inverted data until its result is due.
`ifndef WIDTH
`define WIDTH 8
`endif

module tb_alu_req_scheduler;

  localparam int NUM_REQ = 4;
  localparam int W       = `WIDTH;
  localparam int ALU_LAT = 1;
  localparam int MUL_LAT = 3;
  localparam int IDW     = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NUM_REQ-1:0]     req = '0;
  logic [NUM_REQ-1:0]     req_mode;
  logic [NUM_REQ*4-1:0]   req_cmd;
  logic [NUM_REQ*W-1:0]   req_opa;
  logic [NUM_REQ*W-1:0]   req_opb;
  logic [NUM_REQ-1:0]     req_cin;
  logic [NUM_REQ*2-1:0]   req_inp_valid;
  logic [NUM_REQ-1:0]     gnt;
  logic                   alu_ce, alu_mode, alu_cin;
  logic [3:0]             alu_cmd;
  logic [W-1:0]           alu_opa, alu_opb;
  logic [1:0]             alu_inp_valid;
  logic [W:0]             alu_res = '0;
  logic [5:0]             alu_flags = '0;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b1;
  logic [IDW-1:0]         rsp_id;
  logic [W:0]             rsp_res;
  logic [5:0]             rsp_flags;

  // Per-requester payload as seen by the stimulus code.
  logic       p_mode [NUM_REQ];
  logic [3:0] p_cmd  [NUM_REQ];
  logic [W-1:0] p_opa [NUM_REQ];
  logic [W-1:0] p_opb [NUM_REQ];
  logic       p_cin  [NUM_REQ];
  logic [1:0] p_iv   [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
    assign req_mode[g]             = p_mode[g];
    assign req_cmd[g*4 +: 4]       = p_cmd[g];
    assign req_opa[g*W +: W]       = p_opa[g];
    assign req_opb[g*W +: W]       = p_opb[g];
    assign req_cin[g]              = p_cin[g];
    assign req_inp_valid[g*2 +: 2] = p_iv[g];
  end

  alu_req_scheduler #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (W),
    .ALU_LAT (ALU_LAT),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_mode      (req_mode),
    .req_cmd       (req_cmd),
    .req_opa       (req_opa),
    .req_opb       (req_opb),
    .req_cin       (req_cin),
    .req_inp_valid (req_inp_valid),
    .gnt           (gnt),
    .alu_ce        (alu_ce),
    .alu_mode      (alu_mode),
    .alu_cin       (alu_cin),
    .alu_cmd       (alu_cmd),
    .alu_opa       (alu_opa),
    .alu_opb       (alu_opb),
    .alu_inp_valid (alu_inp_valid),
    .alu_res       (alu_res),
    .alu_flags     (alu_flags),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_res       (rsp_res),
    .rsp_flags     (rsp_flags)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // ---------------- reference behaviour ----------------
  function automatic logic is_mul_ref(input logic mode, input logic [3:0] cmd);
    return mode && (cmd == 4'd9 || cmd == 4'd10);
  endfunction

  // Returns {res, err, oflow, cout, g, l, e}.
  function automatic logic [W+6:0] alu_ref(input logic mode, input logic [3:0] cmd,
                                           input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic [1:0] iv);
    logic [W:0] res;
    logic err, ofl, cout;
    int ai, bi;
    ai = int'(a); bi = int'(b);
    err = (iv != 2'b11); ofl = 1'b0; cout = 1'b0; res = '0;
    if (!mode) res = {1'b0, a & b};
    else begin
      case (cmd)
        4'd0:  begin res = (W+1)'(ai + bi); cout = res[W]; end
        4'd1:  begin res = (W+1)'(ai - bi); ofl = (ai < bi); end
        4'd2:  begin res = (W+1)'(ai + bi + int'(cin)); cout = res[W]; end
        4'd9:  res = (W+1)'((ai + 1) * (bi + 1));
        4'd10: res = (W+1)'((ai * 2) * bi);
        default: err = 1'b1;
      endcase
    end
    if (err) begin res = '0; ofl = 1'b0; cout = 1'b0; end
    return {res, err, ofl, cout, a > b, a < b, a == b};
  endfunction

  // Behavioural ALU: result appears only once the op has been enabled for its
  // full latency; before that the outputs carry the inverted result.
  int   alu_age = 0;
  logic alu_prev_ce = 1'b0;
  logic [W+6:0] alu_r;
  always @(posedge clk) begin
    if (alu_ce) begin
      alu_age = alu_prev_ce ? alu_age + 1 : 1;
      alu_r   = alu_ref(alu_mode, alu_cmd, alu_opa, alu_opb, alu_cin, alu_inp_valid);
      if (alu_age >= (is_mul_ref(alu_mode, alu_cmd) ? MUL_LAT : ALU_LAT))
        {alu_res, alu_flags} <= alu_r;
      else
        {alu_res, alu_flags} <= ~alu_r;
    end
    alu_prev_ce = alu_ce;
  end

  // Arbitration rule: first requester at or after the pointer, or lowest index.
  function automatic int pick(input logic [NUM_REQ-1:0] r, input int ptr);
`ifdef ALU_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) if (r[IDW'(i)]) return i;
`else
    for (int k = 0; k < NUM_REQ; k++) if (r[IDW'((ptr + k) % NUM_REQ)]) return (ptr + k) % NUM_REQ;
`endif
    return 0;
  endfunction

  typedef struct {
    int         id;
    logic [W:0] res;
    logic [5:0] flags;
  } rsp_t;
  rsp_t exp_q[$];

  // Transaction-level model: one op in flight; grant on the first edge idle with
  // requests; response visible lat+1 cycles after grant; idle after the edge
  // that sees ready while the response is visible.
  int   ecnt = 0, t_grant = 0, t_valid = 0, m_lat = 0, m_id = 0, m_rr = 0;
  bit   m_busy = 0, exp_ce = 0, exp_valid = 0;
  logic [NUM_REQ-1:0] exp_gnt = '0;
  logic m_mode = 0, m_cin = 0;
  logic [3:0] m_cmd = '0;
  logic [W-1:0] m_opa = '0, m_opb = '0;
  logic [1:0] m_iv = '0;
  logic [W+6:0] m_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_rr = 0; exp_q.delete();
      exp_gnt = '0; exp_ce = 0; exp_valid = 0;
    end else begin
      ecnt++;
      exp_gnt = '0;
      if (!m_busy) begin
        if (|req) begin
          m_id   = pick(req, m_rr);
          m_mode = p_mode[IDW'(m_id)]; m_cmd = p_cmd[IDW'(m_id)];
          m_opa  = p_opa[IDW'(m_id)];  m_opb = p_opb[IDW'(m_id)];
          m_cin  = p_cin[IDW'(m_id)];  m_iv  = p_iv[IDW'(m_id)];
          m_lat  = is_mul_ref(m_mode, m_cmd) ? MUL_LAT : ALU_LAT;
          t_grant = ecnt;
          t_valid = ecnt + m_lat + 1;
          exp_gnt[IDW'(m_id)] = 1'b1;
          m_busy = 1;
          m_r = alu_ref(m_mode, m_cmd, m_opa, m_opb, m_cin, m_iv);
          exp_q.push_back('{id: m_id, res: m_r[W+6:6], flags: m_r[5:0]});
        end
      end else if (ecnt > t_valid && rsp_ready) begin
        m_busy = 0;
        m_rr   = (m_id + 1) % NUM_REQ;
      end
      exp_ce    = m_busy && (ecnt <= t_grant + m_lat);
      exp_valid = m_busy && (ecnt >= t_valid);
    end
  end

  // Monitor: compares DUT outputs each cycle, away from the active edge.
  always @(negedge clk) begin
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    check("alu_ce", 32'(alu_ce), 32'(exp_ce));
    if (exp_ce) begin
      check("alu_mode", 32'(alu_mode), 32'(m_mode));
      check("alu_cmd", 32'(alu_cmd), 32'(m_cmd));
      check("alu_opa", 32'(alu_opa), 32'(m_opa));
      check("alu_opb", 32'(alu_opb), 32'(m_opb));
      check("alu_cin", 32'(alu_cin), 32'(m_cin));
      check("alu_inp_valid", 32'(alu_inp_valid), 32'(m_iv));
    end
    if (exp_valid) begin
      check("rsp_pending", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) begin
        check("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
        check("rsp_res", 32'(rsp_res), 32'(exp_q[0].res));
        check("rsp_flags", 32'(rsp_flags), 32'(exp_q[0].flags));
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [3:0] cmd_tab [6] = '{4'd0, 4'd1, 4'd2, 4'd9, 4'd10, 4'd7};

  task automatic rand_payload(input logic [IDW-1:0] k);
    p_mode[k] = ($urandom % 4) != 0;
    p_cmd[k]  = cmd_tab[$urandom % 6];
    p_opa[k]  = W'($urandom);
    p_opb[k]  = W'($urandom);
    p_cin[k]  = 1'($urandom);
    p_iv[k]   = (($urandom % 8) == 0) ? 2'($urandom) : 2'b11;
  endtask

  // Single request; n counts negedges after the request is raised.
  task automatic issue_one(input logic [IDW-1:0] id, input logic mode, input logic [3:0] cmd,
                           input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] iv,
                           output int n_gnt, output int n_rsp, output logic [IDW-1:0] r_id,
                           output logic [W:0] r_res, output logic [5:0] r_flags);
    bit got;
    @(posedge clk); #1;
    p_mode[id] = mode; p_cmd[id] = cmd; p_opa[id] = a; p_opb[id] = b;
    p_cin[id] = 1'b0; p_iv[id] = iv; req[id] = 1'b1; rsp_ready = 1'b1;
    n_gnt = 0; n_rsp = 0; got = 0; r_id = '0; r_res = '0; r_flags = '0;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(negedge clk);
      if (gnt[id]) begin n_gnt = n; req[id] = 1'b0; end
      if (rsp_valid) begin got = 1; n_rsp = n; r_id = rsp_id; r_res = rsp_res; r_flags = rsp_flags; end
    end
    check("rsp_timeout", 32'(got), 32'd1);
    @(posedge clk); #1;
  endtask

  int ng, nr, cnt_v, n_order;
  logic [IDW-1:0] rid;
  logic [W:0] rres;
  logic [5:0] rflg;
  int order [5];
  int exp_order [5];

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      p_mode[IDW'(i)] = 0; p_cmd[IDW'(i)] = '0; p_opa[IDW'(i)] = '0;
      p_opb[IDW'(i)] = '0; p_cin[IDW'(i)] = 0; p_iv[IDW'(i)] = 2'b11;
    end
`ifdef ALU_SCHED_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset in the middle of a multiply: everything drops at once, no response later.
    @(posedge clk); #1;
    p_mode[1] = 1; p_cmd[1] = 4'd9; p_opa[1] = 8'd5; p_opb[1] = 8'd6; p_iv[1] = 2'b11;
    req[1] = 1'b1;
    @(posedge clk); #1 req[1] = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_alu_ce", 32'(alu_ce), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_opa", 32'(alu_opa), 32'd0);
    check("rst_rsp_res", 32'(rsp_res), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cnt_v = 0;
    repeat (10) begin @(negedge clk); if (rsp_valid) cnt_v++; end
    check("rsp_after_reset", 32'(cnt_v), 32'd0);

    // All requesters held high from a fresh pointer.
    @(posedge clk); #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      p_mode[IDW'(i)] = 1; p_cmd[IDW'(i)] = 4'd0;
      p_opa[IDW'(i)] = W'(i * 16); p_opb[IDW'(i)] = W'(i);
    end
    req = '1; rsp_ready = 1'b1; n_order = 0;
    for (int n = 0; n < 100 && n_order < 5; n++) begin
      @(negedge clk);
      if (gnt != '0) begin
        for (int i = 0; i < NUM_REQ; i++) if (gnt[IDW'(i)]) order[n_order] = i;
        n_order++;
      end
    end
    req = '0;
    check("order_count", 32'(n_order), 32'd5);
    for (int k = 0; k < 5; k++) check($sformatf("order_%0d", k), 32'(order[k]), 32'(exp_order[k]));
    repeat (10) @(posedge clk);

    // Single ADD on requester 2.
    issue_one(2'd2, 1'b1, 4'd0, 8'hF0, 8'h20, 2'b11, ng, nr, rid, rres, rflg);
    check("add_gnt_cycle", 32'(ng), 32'd2);
    check("add_rsp_cycle", 32'(nr), 32'd4);
    check("add_id", 32'(rid), 32'd2);
    check("add_res", 32'(rres), 32'h110);
    check("add_cout", 32'(rflg[3]), 32'd1);

    // Multiply latency.
    issue_one(2'd0, 1'b1, 4'd9, 8'd3, 8'd4, 2'b11, ng, nr, rid, rres, rflg);
    check("mul_res", 32'(rres), 32'd20);
    check("mul_latency", 32'(nr - ng), 32'(MUL_LAT + 1));

    // Invalid operands: error flag returned, scheduler ready again right away.
    issue_one(2'd1, 1'b1, 4'd0, 8'd7, 8'd9, 2'b00, ng, nr, rid, rres, rflg);
    check("err_flag", 32'(rflg[5]), 32'd1);
    check("err_id", 32'(rid), 32'd1);
    issue_one(2'd3, 1'b0, 4'd0, 8'hAA, 8'h0F, 2'b11, ng, nr, rid, rres, rflg);
    check("after_err_gnt_cycle", 32'(ng), 32'd2);
    check("logic_res", 32'(rres), 32'h00A);

    // Back-pressure: response held, no new grant until the handshake.
    @(posedge clk); #1;
    p_mode[0] = 1; p_cmd[0] = 4'd1; p_opa[0] = 8'h40; p_opb[0] = 8'h10; p_iv[0] = 2'b11;
    req[0] = 1'b1; rsp_ready = 1'b0; cnt_v = 0;
    for (int n = 0; n < 40 && cnt_v == 0; n++) begin
      @(negedge clk);
      if (gnt[0]) req[0] = 1'b0;
      if (rsp_valid) cnt_v = 1;
    end
    check("bp_rsp_seen", 32'(cnt_v), 32'd1);
    p_mode[3] = 1; p_cmd[3] = 4'd0; p_opa[3] = 8'h01; p_opb[3] = 8'h02; req[3] = 1'b1;
    cnt_v = 0;
    repeat (5) begin @(negedge clk); if (gnt != '0) cnt_v++; end
    check("bp_no_gnt", 32'(cnt_v), 32'd0);
    check("bp_res_held", 32'(rsp_res), 32'h030);
    rsp_ready = 1'b1; ng = 0;
    for (int n = 1; n <= 10 && ng == 0; n++) begin
      @(negedge clk);
      if (gnt[3]) begin ng = n; req[3] = 1'b0; end
    end
    check("bp_next_gnt_cycle", 32'(ng), 32'd2);
    repeat (10) @(posedge clk);

    // Randomized traffic with random back-pressure.
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[IDW'(i)]) begin
          req[IDW'(i)] = ($urandom % 2) == 1;
          rand_payload(IDW'(i));
        end else if (req[IDW'(i)]) begin
          if (($urandom % 16) == 0) req[IDW'(i)] = 1'b0;
        end else if (($urandom % 4) == 0) begin
          rand_payload(IDW'(i));
          req[IDW'(i)] = 1'b1;
        end
      end
      rsp_ready = ($urandom % 4) != 0;
    end
    @(posedge clk); #1;
    req = '0; rsp_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
